// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, op classes, funct3 values and the
// arbiter FSM/issue types used by the ALU arbiter and its neighbours.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_LDSW   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_UTYPE  = 2'b11
  } aluop_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } issue_t;

  // Reference mapping used by the external decoder; U-type falls through to ADD.
  function automatic alu_ctrl_t alu_decode(input logic [1:0] op,
                                           input logic [2:0] funct3,
                                           input logic       funct7b5);
    alu_ctrl_t ctrl;
    ctrl = ALU_ADD;
    case (op)
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADD_SUB: ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_SLL:     ctrl = ALU_SLL;
          F3_SLT:     ctrl = ALU_SLT;
          F3_SLTU:    ctrl = ALU_SLTU;
          F3_XOR:     ctrl = ALU_XOR;
          F3_SR:      ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          F3_OR:      ctrl = ALU_OR;
          default:    ctrl = ALU_AND;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals between the two requesters,
// the shared ALU and the arbiter (slave side = arbiter).
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][1:0]      req_alu_op;
  logic [1:0][2:0]      req_funct3;
  logic [1:0]           req_funct7b5;
  logic [1:0][XLEN-1:0] req_a;
  logic [1:0][XLEN-1:0] req_b;

  logic [1:0]           alu_op;
  logic [2:0]           alu_funct3;
  logic                 alu_funct7b5;
  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [XLEN-1:0]      alu_result;
  logic                 alu_zero;

  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [XLEN-1:0]      rsp_result;
  logic                 rsp_zero;
  logic                 busy;

  modport master (
    output req_valid, req_alu_op, req_funct3, req_funct7b5, req_a, req_b,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_op, alu_funct3, alu_funct7b5, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_alu_op, req_funct3, req_funct7b5, req_a, req_b,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_op, alu_funct3, alu_funct7b5, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_zero, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; purely combinational, the caller owns the
// priority pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, one registered
// issue cycle, then the captured result is held until its owner accepts it.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  arb_if
);

  arb_state_t      state_q, state_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  issue_t          issue_q, issue_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [1:0]      gnt;

  rr_arb2 u_rr_arb2 (
    .req  (arb_if.req_valid),
    .prio (prio_q),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      issue_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      issue_q  <= issue_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    issue_d  = issue_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          // gnt is one-hot here, so bit 1 is the winning requester index.
          owner_d         = gnt[1];
          prio_d          = ~gnt[1];
          issue_d.op       = arb_if.req_alu_op[gnt[1]];
          issue_d.funct3   = arb_if.req_funct3[gnt[1]];
          issue_d.funct7b5 = arb_if.req_funct7b5[gnt[1]];
          issue_d.a        = arb_if.req_a[gnt[1]];
          issue_d.b        = arb_if.req_b[gnt[1]];
          state_d          = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = arb_if.alu_result;
        zero_d   = arb_if.alu_zero;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (arb_if.rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign arb_if.req_ready[gi] = (state_q == ST_IDLE) && gnt[gi];
      assign arb_if.rsp_valid[gi] = (state_q == ST_RESP) && (owner_q == 1'(gi));
    end
  endgenerate

  // ALU inputs come straight from the issue registers and hold between issues.
  assign arb_if.alu_op       = issue_q.op;
  assign arb_if.alu_funct3   = issue_q.funct3;
  assign arb_if.alu_funct7b5 = issue_q.funct7b5;
  assign arb_if.alu_a        = issue_q.a;
  assign arb_if.alu_b        = issue_q.b;

  assign arb_if.rsp_result = result_q;
  assign arb_if.rsp_zero   = zero_q;
  assign arb_if.busy       = (state_q != ST_IDLE);

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(arb_if.req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(arb_if.rsp_valid));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_RESP) |=> ((state_q != ST_RESP) || $stable(result_q)));

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single datapath ALU (decoder plus ALU) between two requesters, requester 0 being the core datapath and requester 1 a secondary unit such as an address or branch-target helper. It uses round-robin arbitration and a valid/ready handshake on both the request and response sides. Each accepted request is registered, presented to the ALU for exactly one cycle, and its result is captured and held until the owning requester takes it. The block sits between the requesters and the ALU decoder/ALU pair, and is the only driver of the ALU inputs.

## Interface
- XLEN, 32, operand/result width.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accept; at most one bit set.
- req_alu_op  in  2x2  per-requester ALU op class: 00 ld/st, 01 branch, 10 R/I-type, 11 U-type.
- req_funct3  in  2x3  per-requester funct3.
- req_funct7b5  in  2  per-requester funct7 bit 5.
- req_a, req_b  in  2xXLEN  per-requester operands.
- alu_op, alu_funct3, alu_funct7b5  out  2/3/1  to the ALU decoder.
- alu_a, alu_b  out  XLEN  to the ALU.
- alu_result  in  XLEN  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  2  per-requester response valid; at most one bit set.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  XLEN  captured result, shared by both requesters.
- rsp_zero  out  1  captured zero flag.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - The grant `g` is chosen from `req_valid` by round-robin. The priority pointer `prio` names the favoured requester; it resets to 0.
  - If only one requester is valid, that one wins. If both are valid, `prio` wins.
  - `req_ready[g]=1` combinationally; this depends on `req_valid`.
  - On the handshake edge:
    - latch op, funct3, funct7b5, a and b into the issue registers;
    - set owner=g and `prio`=~g;
    - go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The `alu_*` outputs come from the issue registers, so they are registered and stable for the whole cycle.
  - At the edge, capture `alu_result` and `alu_zero` into `rsp_result` and `rsp_zero`, then go to RESP.
  - `req_ready`=0.
- RESP:
  - `rsp_valid[owner]=1`.
  - When `rsp_ready[owner]` is high at an edge, go to IDLE.
  - `rsp_ready` of the non-owner is ignored. `req_ready`=0.
- The `alu_*` outputs hold the last issued values outside EXEC. The ALU output is ignored in those states.
- Op class 11 is passed through unchanged; the decoder yields ADD.
- `prio` changes only on request acceptance, never on idle cycles.
- A requester may drop `req_valid` before its grant; nothing is latched in that case.
- Reset asserted mid-operation aborts the transaction. No response is produced, and all state returns to reset values immediately (asynchronously).

## Timing
- Reset values:
  - `req_ready`=0 when no request is valid;
  - `rsp_valid`=00, `rsp_result`=0, `rsp_zero`=0, `busy`=0;
  - `alu_op`=00, `alu_funct3`=0, `alu_funct7b5`=0, `alu_a`=0, `alu_b`=0.
- A request accepted at edge N makes EXEC active in cycle N+1. `rsp_valid` is high from cycle N+2.
- Minimum occupancy is 3 cycles per transaction, so peak throughput is one result per 3 cycles.
- The next request can be accepted in the cycle after the response handshake.
- A stalled `rsp_ready` holds RESP indefinitely. `rsp_result` and `rsp_zero` stay stable while `rsp_valid` is high.
- The path `req_valid`→`req_ready` is combinational. No other input-to-output combinational paths exist.

## Structure
- A shared package `alu_pkg` holds:
  - the ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001;
  - the ALUOP codes (LDSW 00, BRANCH 01, RTYPE 10, UTYPE 11);
  - the funct3 constants;
  - the FSM state enum `arb_state_t`.
- The decoder and ALU sit outside this block. The top level wires `alu_*` to them.
- Sub-module: `rr_arb2`, a two-way round-robin grant with inputs `req[1:0]` and `prio` and output `gnt[1:0]` one-hot. It is combinational; the pointer register stays in `alu_arbiter`.

## Test plan
- **Reset:** `rst_n` low, then release.
  - All outputs at their reset values.
  - With `req_valid`=01 in the first cycle after release, `req_ready`=01 and requester 0 is granted.
- **Single R-type SUB:**
  - Stimulus: req 0 with op=10, funct3=000, funct7b5=1, a=10, b=3, and an ALU model attached.
  - `alu_*` carry those values in N+1.
  - `rsp_valid`=01 and `rsp_result`=7 at N+2.
  - `rsp_zero`=1 when a=b=5.
- **Contention and fairness:**
  - Stimulus: both requesters valid continuously, `rsp_ready` always 1.
  - Grants alternate 0,1,0,1, each response going to the matching `rsp_valid` bit, with 3 cycles between grants.
- **Response backpressure:**
  - Stimulus: `rsp_ready[1]`=0 for 5 cycles after `rsp_valid`=10.
  - `rsp_result` stays constant, `busy`=1, and `req_ready`=00 despite req 0 being valid.
  - Req 0 is granted the cycle after `rsp_ready[1]` rises.
- **Reset mid-transaction:**
  - Stimulus: assert `rst_n` low during EXEC.
  - `busy` and `rsp_valid` drop to 0 immediately.
  - No response is produced after release, and `prio` is back to 0.
- **Branch/ld-st pass-through:**
  - Stimulus: op=01 with a=b=9, then op=00 with a=100, b=4.
  - `rsp_zero`=1, then `rsp_result`=104.
